instruction_decode: RTL
=======================

Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction_fetch. Consumes the fetched 32-bit RV32I instruction and its PC.
- Extracts the instruction fields, generates the sign-extended immediate, and reads two operands from an internal 32x32 register file. The register file has a write-back port with write-first bypass.
- All decoded results are registered into the ID/EX boundary, one cycle after the instruction is presented.

Parameters:
- XLEN, 32, data/PC width (RV32I only; no other value supported)
- REG_ADDR_W, 5, register index width (32 architectural registers)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instruction  input  32  instruction from fetch stage
- pc  input  32  PC of instruction
- if_valid  input  1  instruction/pc are valid this cycle
- stall  input  1  hold ID/EX outputs unchanged
- flush  input  1  squash; insert bubble
- wb_en  input  1  register-file write enable
- wb_rd  input  5  write-back destination
- wb_data  input  32  write-back data
- id_valid  output  1  ID/EX contents valid
- id_pc  output  32  registered PC
- opcode  output  7  instr[6:0]
- rd  output  5  instr[11:7]
- funct3  output  3  instr[14:12]
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]
- funct7  output  7  instr[31:25]
- rs1_data  output  32  operand 1
- rs2_data  output  32  operand 2
- imm  output  32  sign-extended immediate
- illegal  output  1  unsupported opcode on a valid instruction

Behaviour:
- Reset (async, active-high): every output is 0, including id_valid=0. All 32 registers are cleared to 0.
- Latency: inputs sampled at a rising edge appear on the outputs immediately after that edge (1 cycle).
- Update priority per edge: reset > flush > stall > normal load.
  - Flush: id_valid<=0 and every other output <=0, even if stall is also high.
  - Stall (no flush): all outputs hold their current values.
  - Normal: id_valid<=if_valid. Fields, id_pc, operands and imm are loaded from the current inputs. When if_valid=0 the data outputs are don't-care, but illegal<=0.
- Register file:
  - Write at the rising edge when wb_en=1 and wb_rd!=0. Writes to x0 are ignored.
  - Writes proceed regardless of stall/flush.
  - x0 always reads 0.
- Bypass: if wb_en=1, wb_rd!=0 and wb_rd equals rs1 (or rs2) in the same cycle, the corresponding operand is wb_data, not the stale array value.
- Immediate selection by opcode, with sign taken from instr[31]:
  - I-type (0010011, 0000011, 1100111, 1110011): instr[31:20]
  - S-type (0100011): {instr[31:25], instr[11:7]}
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All other opcodes (including 0110011 and 0001111): imm=0
- Illegal detection:
  - illegal=1 when if_valid=1 and opcode is not one of the eleven listed above (those above plus 0110011, 0001111).
  - This includes any opcode with instr[1:0]!=11.
  - id_valid is still 1 for an illegal instruction; downstream traps.
- Operands are always read from rs1/rs2 field positions, even for U/J formats (downstream ignores them).

Test Plan:
- Reset asserted mid-run, asynchronously between edges -> all outputs 0 immediately, no wait for an edge. Registers read 0 after release.
- if_valid=1, instruction=0x00500093 (addi x1,x0,5), pc=0x00000010 -> next cycle: id_valid=1, id_pc=0x10, opcode=0x13, rd=1, rs1=0, imm=0x00000005, rs1_data=0, illegal=0.
- Same cycle: wb_en=1, wb_rd=2, wb_data=0xDEADBEEF, instruction=0x002101B3 (add x3,x2,x2) -> rs1_data=rs2_data=0xDEADBEEF (bypass). A later read of x2 also returns 0xDEADBEEF.
- instruction=0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8. Then instruction=0x00000000 -> illegal=1, id_valid=1.
- Outputs loaded with addi; then stall=1 for 3 cycles with new instructions on the input -> outputs unchanged. Then stall=1 and flush=1 together -> id_valid=0, all fields 0.
- wb_en=1, wb_rd=0, wb_data=0x12345678 -> a subsequent read of x0 returns 0. The bypass does not fire for rs1=0.

Source files
------------

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//
// Purpose:
//   RV32I decode stage. It splits the fetched instruction into its fields and
//   builds the sign-extended immediate. It reads two operands from a 32x32
//   register file, which has a write-back port with write-first bypass. It
//   also flags unsupported opcodes. All results are registered into the
//   ID/EX boundary one cycle after the instruction is presented.
//
//   Per-edge update priority of the ID/EX registers:
//     reset > flush > stall > normal load.
//
// Ports:
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   instruction, pc      : fetched instruction and its PC
//   if_valid             : instruction/pc valid this cycle
//   stall                : hold ID/EX outputs
//   flush                : squash ID/EX into a bubble (all zero)
//   wb_en, wb_rd, wb_data: register-file write-back port
//   id_valid, id_pc      : registered valid and PC
//   opcode .. funct7     : registered instruction fields
//   rs1_data, rs2_data   : registered operands
//   imm                  : registered sign-extended immediate
//   illegal              : unsupported opcode on a valid instruction
// ---------------------------------------------------------------------------
module instruction_decode #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       instruction,
    input  logic [XLEN-1:0]       pc,
    input  logic                  if_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  id_valid,
    output logic [XLEN-1:0]       id_pc,
    output logic [6:0]            opcode,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [2:0]            funct3,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [6:0]            funct7,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Register file
    logic [XLEN-1:0] r_regs [NUM_REGS];

    // Field extraction
    logic [6:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [2:0]            w_funct3;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [6:0]            w_funct7;
    logic [XLEN-1:0]       w_imm;
    logic                  w_legal;
    logic [XLEN-1:0]       w_rs1_data;
    logic [XLEN-1:0]       w_rs2_data;
    logic                  w_wb_fire;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_funct7 = instruction[31:25];

    assign w_wb_fire = wb_en && (wb_rd != '0);

    // Register-file write. x0 is never written, so it stays zero. Writes
    // happen regardless of stall/flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_fire) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Operand read with write-first bypass. x0 takes priority, so a
    // (suppressed) write-back to x0 can never leak through the bypass.
    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        if (w_rs1 == '0) begin
            w_rs1_data = '0;
        end else if (w_wb_fire && (wb_rd == w_rs1)) begin
            w_rs1_data = wb_data;
        end
    end

    always_comb begin
        w_rs2_data = r_regs[w_rs2];
        if (w_rs2 == '0) begin
            w_rs2_data = '0;
        end else if (w_wb_fire && (wb_rd == w_rs2)) begin
            w_rs2_data = wb_data;
        end
    end

    // Immediate generation and legality. Every legal opcode has
    // instr[1:0]=11, so anything else falls through to illegal.
    always_comb begin
        w_imm   = '0;
        w_legal = 1'b1;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                w_imm = {{20{instruction[31]}}, instruction[31:20]};
            OP_STORE:
                w_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OP_BRANCH:
                w_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {instruction[31:12], 12'b0};
            OP_JAL:
                w_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            OP_REG, OP_FENCE:
                w_imm = '0;
            default: begin
                w_imm   = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // ID/EX boundary registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            opcode   <= '0;
            rd       <= '0;
            funct3   <= '0;
            rs1      <= '0;
            rs2      <= '0;
            funct7   <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm      <= '0;
            illegal  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            opcode   <= '0;
            rd       <= '0;
            funct3   <= '0;
            rs1      <= '0;
            rs2      <= '0;
            funct7   <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm      <= '0;
            illegal  <= 1'b0;
        end else if (!stall) begin
            id_valid <= if_valid;
            id_pc    <= pc;
            opcode   <= w_opcode;
            rd       <= w_rd;
            funct3   <= w_funct3;
            rs1      <= w_rs1;
            rs2      <= w_rs2;
            funct7   <= w_funct7;
            rs1_data <= w_rs1_data;
            rs2_data <= w_rs2_data;
            imm      <= w_imm;
            illegal  <= if_valid && !w_legal;
        end
    end

endmodule
